// File: rtl/network_interface.sv
// rtl/network_interface.sv - NoC local-port endpoint: injection FIFO with 4-phase initiator, ejection register with 4-phase responder
module network_interface #(
   parameter int ID               = -1,
   parameter int SIZE             = 8,
   parameter int DESTINATION_BITS = 4,
   parameter int DEPTH_LOG2       = 2,
   parameter int COUNT_BITS       = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  host_in_valid,
   output logic                  host_in_ready,
   input  logic [SIZE-1:0]       host_in_data,
   output logic                  host_out_valid,
   input  logic                  host_out_ready,
   output logic [SIZE-1:0]       host_out_data,
   output logic                  net_tx_req,
   input  logic                  net_tx_ack,
   output logic [SIZE-1:0]       net_tx_data,
   input  logic                  net_rx_req,
   output logic                  net_rx_ack,
   input  logic [SIZE-1:0]       net_rx_data,
   output logic [COUNT_BITS-1:0] sent_count,
   output logic [COUNT_BITS-1:0] recv_count,
   output logic                  misroute
);
   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam logic [DESTINATION_BITS-1:0] C_ID = DESTINATION_BITS'(ID);

   typedef enum logic [1:0] {T_IDLE, T_REQ, T_REL} tx_state_t;
   typedef enum logic {R_IDLE, R_ACK} rx_state_t;

   logic [SIZE-1:0]       r_mem [DEPTH];
   logic [DEPTH_LOG2-1:0] r_wr_ptr;
   logic [DEPTH_LOG2-1:0] r_rd_ptr;
   logic [DEPTH_LOG2:0]   r_count;
   logic                  r_run;

   tx_state_t             r_tx_state;
   logic                  r_tx_req;
   logic [SIZE-1:0]       r_tx_data;
   logic [COUNT_BITS-1:0] r_sent;

   rx_state_t             r_rx_state;
   logic                  r_rx_ack;
   logic                  r_out_valid;
   logic [SIZE-1:0]       r_out_data;
   logic [COUNT_BITS-1:0] r_recv;
   logic                  r_misroute;

   logic w_full;
   logic w_empty;
   logic w_push;
   logic w_pop;

   // r_run holds ready low through reset and rises on the first edge after release
   assign w_full        = (r_count == (DEPTH_LOG2 + 1)'(DEPTH));
   assign w_empty       = (r_count == '0);
   assign host_in_ready = r_run && !w_full;
   assign w_push        = host_in_valid && host_in_ready;
   assign w_pop         = (r_tx_state == T_IDLE) && !w_empty;

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_run    <= 1'b0;
      end else begin
         r_run <= 1'b1;
         if (w_push) begin
            r_mem[r_wr_ptr] <= host_in_data;
            r_wr_ptr        <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_tx_state <= T_IDLE;
         r_tx_req   <= 1'b0;
         r_tx_data  <= '0;
         r_sent     <= '0;
      end else begin
         case (r_tx_state)
            T_IDLE: if (!w_empty) begin
               r_tx_data  <= r_mem[r_rd_ptr];
               r_tx_req   <= 1'b1;
               r_tx_state <= T_REQ;
            end
            T_REQ: if (net_tx_ack) begin
               r_tx_req   <= 1'b0;
               r_tx_state <= T_REL;
            end
            T_REL: if (!net_tx_ack) begin
               r_sent     <= r_sent + 1'b1;
               r_tx_state <= T_IDLE;
            end
            default: r_tx_state <= T_IDLE;
         endcase
      end
   end

   // Capture only when the register was empty at this edge, so clear and capture never collide
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_rx_state  <= R_IDLE;
         r_rx_ack    <= 1'b0;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_recv      <= '0;
         r_misroute  <= 1'b0;
      end else begin
         if (r_out_valid && host_out_ready) begin
            r_out_valid <= 1'b0;
         end
         case (r_rx_state)
            R_IDLE: if (net_rx_req && !r_out_valid) begin
               r_out_data  <= net_rx_data;
               r_out_valid <= 1'b1;
               r_rx_ack    <= 1'b1;
               r_rx_state  <= R_ACK;
               if (net_rx_data[DESTINATION_BITS-1:0] != C_ID) begin
                  r_misroute <= 1'b1;
               end
            end
            R_ACK: if (!net_rx_req) begin
               r_rx_ack   <= 1'b0;
               r_recv     <= r_recv + 1'b1;
               r_rx_state <= R_IDLE;
            end
         endcase
      end
   end

   assign net_tx_req     = r_tx_req;
   assign net_tx_data    = r_tx_data;
   assign sent_count     = r_sent;
   assign net_rx_ack     = r_rx_ack;
   assign host_out_valid = r_out_valid;
   assign host_out_data  = r_out_data;
   assign recv_count     = r_recv;
   assign misroute       = r_misroute;
endmodule

// File: tb/tb_network_interface.sv
// tb/tb_network_interface.sv - randomized bench for network_interface with queue-based router/host model
module tb_network_interface;
   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       host_in_valid = 1'b0;
   logic       host_in_ready;
   logic [7:0] host_in_data = '0;
   logic       host_out_valid;
   logic       host_out_ready = 1'b0;
   logic [7:0] host_out_data;
   logic       net_tx_req;
   logic       net_tx_ack = 1'b0;
   logic [7:0] net_tx_data;
   logic       net_rx_req = 1'b0;
   logic       net_rx_ack;
   logic [7:0] net_rx_data = '0;
   logic [3:0] sent_count;
   logic [3:0] recv_count;
   logic       misroute;

   always #5 clk = ~clk;

   network_interface #(
      .ID(3), .SIZE(8), .DESTINATION_BITS(4), .DEPTH_LOG2(2), .COUNT_BITS(4)
   ) dut (
      .clk(clk), .reset(reset),
      .host_in_valid(host_in_valid), .host_in_ready(host_in_ready), .host_in_data(host_in_data),
      .host_out_valid(host_out_valid), .host_out_ready(host_out_ready), .host_out_data(host_out_data),
      .net_tx_req(net_tx_req), .net_tx_ack(net_tx_ack), .net_tx_data(net_tx_data),
      .net_rx_req(net_rx_req), .net_rx_ack(net_rx_ack), .net_rx_data(net_rx_data),
      .sent_count(sent_count), .recv_count(recv_count), .misroute(misroute)
   );

   int n_checks = 0;
   int n_errors = 0;

   // Expected contents: items accepted but not yet launched, items still to inject/send, items awaiting the host
   logic [7:0] tx_q[$];
   logic [7:0] inj_q[$];
   logic [7:0] rx_send[$];
   logic [7:0] exp_out[$];
   logic [7:0] cur_tx = '0;
   logic       prev_req = 1'b0;
   int         tx_stall_pct = 0;
   int         inj_pct = 100;
   int         rx_pct = 100;
   int         out_pct = 100;
   int         rx_ph = 0;
   logic [3:0] m_sent = '0;
   logic [3:0] m_recv = '0;
   logic       m_mis = 1'b0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      chk("sent_count", 32'(sent_count), 32'(m_sent));
      if (net_tx_req && !prev_req) begin
         if (tx_q.size() == 0) chk("tx_spurious_req", 32'(net_tx_req), 32'd0);
         else cur_tx = tx_q.pop_front();
      end
      prev_req = net_tx_req;
      if (net_tx_req || net_tx_ack) chk("tx_data", 32'(net_tx_data), 32'(cur_tx));
      if (net_tx_req && !net_tx_ack) begin
         if ($urandom_range(99) >= tx_stall_pct) net_tx_ack = 1'b1;
      end else if (!net_tx_req && net_tx_ack) begin
         net_tx_ack = 1'b0;
         m_sent = m_sent + 4'd1;
      end
      chk("host_in_ready", 32'(host_in_ready), 32'(tx_q.size() < 4));

      if (rx_ph == 1 && net_rx_ack) begin
         exp_out.push_back(net_rx_data);
         if (net_rx_data[3:0] != 4'd3) m_mis = 1'b1;
         net_rx_req = 1'b0;
         rx_ph = 2;
      end else if (rx_ph == 2 && !net_rx_ack) begin
         m_recv = m_recv + 4'd1;
         rx_ph = 0;
      end
      if (rx_ph == 0 && rx_send.size() > 0 && $urandom_range(99) < rx_pct) begin
         net_rx_data = rx_send.pop_front();
         net_rx_req = 1'b1;
         rx_ph = 1;
      end
      chk("recv_count", 32'(recv_count), 32'(m_recv));
      chk("misroute", 32'(misroute), 32'(m_mis));

      chk("host_out_valid", 32'(host_out_valid), 32'(exp_out.size() > 0));
      if (host_out_valid && exp_out.size() > 0) chk("host_out_data", 32'(host_out_data), 32'(exp_out[0]));
      host_out_ready = ($urandom_range(99) < out_pct);
      if (host_out_valid && host_out_ready && exp_out.size() > 0) void'(exp_out.pop_front());

      host_in_valid = 1'b0;
      if (inj_q.size() > 0 && $urandom_range(99) < inj_pct) begin
         host_in_valid = 1'b1;
         host_in_data = inj_q[0];
         if (host_in_ready) tx_q.push_back(inj_q.pop_front());
      end
   endtask

   task automatic drain(input int budget);
      int n = 0;
      while ((tx_q.size() > 0 || inj_q.size() > 0 || rx_send.size() > 0 || rx_ph != 0 ||
              net_tx_req || net_tx_ack || exp_out.size() > 0 || host_in_valid) && n < budget) begin
         tick();
         n++;
      end
      chk("drain_in_budget", 32'(n < budget), 32'd1);
      repeat (3) tick();
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b0;
      host_in_valid = 1'b1;
      host_in_data = 8'hA5;
      net_tx_ack = 1'b0;
      net_rx_req = 1'b0;
      host_out_ready = 1'b0;
      tx_q.delete(); inj_q.delete(); rx_send.delete(); exp_out.delete();
      rx_ph = 0; m_sent = '0; m_recv = '0; m_mis = 1'b0; prev_req = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_in_ready", 32'(host_in_ready), 32'd0);
      chk("rst_tx_req", 32'(net_tx_req), 32'd0);
      chk("rst_rx_ack", 32'(net_rx_ack), 32'd0);
      chk("rst_out_valid", 32'(host_out_valid), 32'd0);
      chk("rst_out_data", 32'(host_out_data), 32'd0);
      chk("rst_tx_data", 32'(net_tx_data), 32'd0);
      chk("rst_sent", 32'(sent_count), 32'd0);
      chk("rst_recv", 32'(recv_count), 32'd0);
      chk("rst_misroute", 32'(misroute), 32'd0);
      reset = 1'b1;
      host_in_valid = 1'b0;
      @(negedge clk);
      chk("ready_after_release", 32'(host_in_ready), 32'd1);
      chk("fifo_empty_after_release", 32'(net_tx_req), 32'd0);
   endtask

   initial begin
      int n;
      do_reset();

      // single inject: req rises one edge after the write edge
      tx_stall_pct = 0;
      host_in_valid = 1'b1; host_in_data = 8'h35; tx_q.push_back(8'h35);
      tick();
      chk("lat_req_low_at_n", 32'(net_tx_req), 32'd0);
      tick();
      chk("lat_req_high_at_n1", 32'(net_tx_req), 32'd1);
      chk("lat_data", 32'(net_tx_data), 32'h35);
      repeat (4) tick();
      chk("single_sent", 32'(sent_count), 32'd1);

      // fill the FIFO with ack stalled
      tx_stall_pct = 100;
      for (int i = 1; i <= 5; i++) begin
         chk("fill_ready", 32'(host_in_ready), 32'd1);
         host_in_valid = 1'b1; host_in_data = 8'(i); tx_q.push_back(8'(i));
         tick();
      end
      chk("full_ready_low", 32'(host_in_ready), 32'd0);
      repeat (2) begin
         host_in_valid = 1'b1; host_in_data = 8'hEE;
         tick();
      end
      tx_stall_pct = 0;
      drain(200);
      chk("full_sent", 32'(sent_count), 32'd6);

      // ejection backpressure
      out_pct = 0;
      rx_send.push_back(8'h11); rx_send.push_back(8'h22);
      n = 0;
      while (!host_out_valid && n < 50) begin tick(); n++; end
      repeat (8) tick();
      chk("bp_first", 32'(host_out_data), 32'h11);
      chk("bp_ack_low", 32'(net_rx_ack), 32'd0);
      chk("bp_req_pending", 32'(net_rx_req), 32'd1);
      chk("bp_recv1", 32'(recv_count), 32'd1);
      out_pct = 100; tick(); out_pct = 0;
      repeat (6) tick();
      chk("bp_second", 32'(host_out_data), 32'h22);
      chk("bp_recv2", 32'(recv_count), 32'd2);
      out_pct = 100;
      drain(100);

      // misroute is sticky until reset
      do_reset();
      rx_send.push_back(8'h53);
      drain(100);
      chk("mis_after_53", 32'(misroute), 32'd0);
      rx_send.push_back(8'h54);
      drain(100);
      chk("mis_after_54", 32'(misroute), 32'd1);
      rx_send.push_back(8'h63);
      drain(100);
      chk("mis_sticky", 32'(misroute), 32'd1);

      // counter wrap with concurrent random traffic
      do_reset();
      inj_pct = 60; rx_pct = 50; out_pct = 70; tx_stall_pct = 30;
      for (int i = 0; i < 17; i++) inj_q.push_back(8'($urandom));
      for (int i = 0; i < 12; i++) rx_send.push_back(8'($urandom));
      drain(3000);
      chk("sent_wrap", 32'(sent_count), 32'd1);
      chk("recv_concurrent", 32'(recv_count), 32'd12);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end
endmodule
